// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit valid/ready stream multiplexer with one registered
// output stage. The granted channel is either a software-fixed index (mode=0) or chosen
// round-robin among the requesting channels (mode=1). The output word is held stable
// under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NUM_CH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, combinational, at most one bit set
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in fixed mode
//   out_data   registered output word
//   out_ch     channel id that out_data came from
//   out_valid  output word valid
//   out_ready  consumer ready
module stream_mux_rr #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_word;
  logic             xfer;

  // Register is free when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Grant selection; depends only on mode/sel/in_valid/rr_ptr, never on in_ready.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!mode) begin
      if ((32'(sel) < NUM_CH) && in_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end else begin
      // Search rr_ptr, rr_ptr+1, ... modulo NUM_CH; first requester wins.
      for (int k = 0; k < int'(NUM_CH); k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
        if (!grant_any && in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  assign grant_word = in_data[32'(grant_idx) * WIDTH +: WIDTH];

  // rst_n gating keeps producers from seeing a handshake while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_any) in_ready[grant_idx] = 1'b1;
  end

  assign xfer = load_en && grant_any;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = grant_word;
        out_ch_d   = grant_idx;
      end
    end
    if (xfer && mode) begin
      rr_ptr_d = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr (WIDTH=4, NUM_CH=4). A table of per-cycle vectors
// carries inputs plus the expected combinational in_ready and the expected registered
// outputs after the following rising edge; an async-reset sequence is hand-written.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  stream_mux_rr #(
    .WIDTH (4),
    .NUM_CH(4),
    .SEL_W (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [3:0]  exp_odata;
    logic [1:0]  exp_och;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    // Channel words: 16'h8421 -> ch0=1 ch1=2 ch2=4 ch3=8; 16'hA5C3 -> ch0=3 ch1=C ch2=5 ch3=A.
    // Fixed mode, sel 0..3
    vecs[0]  = '{1'b0, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[1]  = '{1'b0, 2'd1, 4'b1111, 16'h8421, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[2]  = '{1'b0, 2'd2, 4'b1111, 16'h8421, 1'b1, 4'b0100, 1'b1, 4'h4, 2'd2};
    vecs[3]  = '{1'b0, 2'd3, 4'b1111, 16'h8421, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    // Round-robin, all valid (pointer starts at 0, untouched by fixed mode)
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b0100, 1'b1, 4'h4, 2'd2};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    // Round-robin, only ch1 and ch3 (pointer = 1)
    vecs[9]  = '{1'b1, 2'd0, 4'b1010, 16'h8421, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[10] = '{1'b1, 2'd0, 4'b1010, 16'h8421, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    vecs[11] = '{1'b1, 2'd0, 4'b1010, 16'h8421, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[12] = '{1'b1, 2'd0, 4'b1010, 16'h8421, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    // Backpressure for 3 cycles, then release (pointer wrapped to 0)
    vecs[13] = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
    vecs[14] = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
    vecs[15] = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
    vecs[16] = '{1'b1, 2'd0, 4'b1111, 16'h8421, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    // Fixed sel=2 with ch2 idle: no grant, output drains, word/ch hold
    vecs[17] = '{1'b0, 2'd2, 4'b1011, 16'h8421, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
    vecs[18] = '{1'b0, 2'd2, 4'b1011, 16'h8421, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
    // Empty register accepts despite out_ready=0; sel change never disturbs held word
    vecs[19] = '{1'b0, 2'd3, 4'b1111, 16'h8421, 1'b0, 4'b1000, 1'b1, 4'h8, 2'd3};
    vecs[20] = '{1'b0, 2'd1, 4'b1111, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
    vecs[21] = '{1'b0, 2'd1, 4'b1111, 16'h8421, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    // Different data, RR pointer = 1 from vec 16
    vecs[22] = '{1'b1, 2'd0, 4'b1111, 16'hA5C3, 1'b1, 4'b0010, 1'b1, 4'hC, 2'd1};
    vecs[23] = '{1'b1, 2'd0, 4'b0001, 16'hA5C3, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0};
    vecs[24] = '{1'b1, 2'd0, 4'b0000, 16'hA5C3, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd0};

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_ch", 32'(out_ch), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      in_data   = vecs[i].data;
      out_ready = vecs[i].oready;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ovalid));
      check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_odata));
      check($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].exp_och));
    end

    // Async reset mid-stream: pointer is 1, so ch1 loads, then reset between edges.
    @(negedge clk);
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 16'h8421;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_out_data", 32'(out_data), 32'h2);
    check("pre_rst_out_ch", 32'(out_ch), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_out_ch0", 32'(out_ch), 32'd0);
    check("post_rst_out_data", 32'(out_data), 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_out_ch1", 32'(out_ch), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
